// File: rtl/scsi_fifo.sv
// ============================================================================
//  Module   : scsi_fifo
//  Purpose  : Longword FIFO between the SCSI sequencer (byte side) and the
//             DMA/CPU bus (longword side) of the SDMAC core. Bytes are packed
//             and unpacked through big-endian lane BO. The module also produces
//             occupancy and byte-offset status for the sequencer.
//  Options  : FIFO_ERR_EN - adds sticky OVF/UNF error outputs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scsi_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        CPUCLK,
  input  logic        RESET_,
  input  logic        FIFO_RST,
  input  logic        S2F,
  input  logic [7:0]  SCSI_DI,
  input  logic        F2S,
  output logic [7:0]  SCSI_DO,
  input  logic        INCBO,
  input  logic        INCNI,
  input  logic        INCNO,
  input  logic        WRLW,
  input  logic [3:0]  BE,
  input  logic [31:0] FIFO_ID,
  output logic [31:0] FIFO_OD,
  output logic        FIFOFULL,
  output logic        FIFOEMPTY,
  output logic        BOEQ3,
  output logic        INCFIFO,
  output logic        DECFIFO
`ifdef FIFO_ERR_EN
  ,
  output logic        OVF,
  output logic        UNF
`endif
);

  localparam int                  c_ENTRIES    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = (DEPTH_LOG2+1)'(c_ENTRIES);
  localparam logic [DEPTH_LOG2:0] c_COUNT_ONE  = (DEPTH_LOG2+1)'(1);

  logic [31:0]           r_mem [c_ENTRIES];
  logic [DEPTH_LOG2-1:0] r_wrptr;
  logic [DEPTH_LOG2-1:0] r_rdptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [1:0]            r_bo;
  logic [7:0]            r_scsi_do;
  logic                  r_incfifo;
  logic                  r_decfifo;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_dec_ok;
  logic                  w_inc_ok;
  logic [3:0]            w_lane_we;
  logic [7:0]            w_lane_data [4];

  assign w_full    = (r_count == c_FULL_COUNT);
  assign w_empty   = (r_count == '0);

  // A retire frees a slot, so a simultaneous commit is legal on a full FIFO;
  // the reverse does not hold because the entry being retired must already exist.
  assign w_dec_ok  = INCNO && !w_empty;
  assign w_inc_ok  = INCNI && (!w_full || w_dec_ok);

  assign FIFO_OD   = r_mem[r_rdptr];
  assign SCSI_DO   = r_scsi_do;
  assign FIFOFULL  = w_full;
  assign FIFOEMPTY = w_empty;
  assign BOEQ3     = (r_bo == 2'd3);
  assign INCFIFO   = r_incfifo;
  assign DECFIFO   = r_decfifo;

  // Per-lane write select: the SCSI byte owns lane BO, the bus fills the rest.
  generate
    for (genvar n = 0; n < 4; n++) begin : g_lane
      assign w_lane_we[n]   = (S2F && (r_bo == 2'(n))) || (WRLW && BE[3-n]);
      assign w_lane_data[n] = (S2F && (r_bo == 2'(n))) ? SCSI_DI : FIFO_ID[31-8*n -: 8];
    end
  endgenerate

  // Entry storage: byte-lane writes into the uncommitted entry at WRPTR.
  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) begin
      for (int i = 0; i < c_ENTRIES; i++) r_mem[i] <= '0;
    end else if (!FIFO_RST) begin
      for (int n = 0; n < 4; n++) begin
        if (w_lane_we[n]) r_mem[r_wrptr][31-8*n -: 8] <= w_lane_data[n];
      end
    end
  end

  // Pointers, occupancy, byte offset and the accepted-increment strobes.
  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) begin
      r_wrptr   <= '0;
      r_rdptr   <= '0;
      r_count   <= '0;
      r_bo      <= '0;
      r_incfifo <= 1'b0;
      r_decfifo <= 1'b0;
    end else if (FIFO_RST) begin
      r_wrptr   <= '0;
      r_rdptr   <= '0;
      r_count   <= '0;
      r_bo      <= '0;
      r_incfifo <= 1'b0;
      r_decfifo <= 1'b0;
    end else begin
      if (w_inc_ok) r_wrptr <= r_wrptr + 1'b1;
      if (w_dec_ok) r_rdptr <= r_rdptr + 1'b1;
      if (w_inc_ok && !w_dec_ok) r_count <= r_count + c_COUNT_ONE;
      else if (w_dec_ok && !w_inc_ok) r_count <= r_count - c_COUNT_ONE;
      if (INCBO) r_bo <= r_bo + 2'd1;
      r_incfifo <= w_inc_ok;
      r_decfifo <= w_dec_ok;
    end
  end

  // SCSI output byte: lane BO of the current head entry, before any retire.
  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) begin
      r_scsi_do <= '0;
    end else if (!FIFO_RST && F2S) begin
      r_scsi_do <= r_mem[r_rdptr][31-8*r_bo -: 8];
    end
  end

`ifdef FIFO_ERR_EN
  logic r_ovf;
  logic r_unf;

  assign OVF = r_ovf;
  assign UNF = r_unf;

  // Sticky flags recording dropped commits and dropped retires.
  always_ff @(posedge CPUCLK or negedge RESET_) begin
    if (!RESET_) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (FIFO_RST) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (INCNI && !w_inc_ok) r_ovf <= 1'b1;
      if (INCNO && !w_dec_ok) r_unf <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
